ndro_emu_bank: RTL and testbench
================================

Name: ndro_emu_bank

Overview:
- Cycle-accurate, synthesizable emulation of a bank of WIDTH non-destructive-readout (NDRO) SFQ cells sharing one readout clock line.
- SFQ pulses are encoded as one-cycle-high strobes on the system clock.
- Critical-timing windows, readout delay and violation detection are expressed in clock cycles.
- Used by FPGA/RTL emulation of extracted SFQ netlists in place of the ps-timed behavioural model; adds width, per-channel error reporting, an error counter and a startup guard.

Parameters:
- WIDTH, 8, number of NDRO channels.
- DLY_RD_OUT, 7, cycles from rd pulse (state 1) to out pulse; legal range 1..31.
- CT_CLR_SET_S0, 2, cycles a set is forbidden after clr while in state 0.
- CT_CLR_SET_S1, 1, cycles a set is forbidden after clr while in state 1.
- CT_RD_CLR, 2, cycles a clr is forbidden after a state-1 read.
- CT_RD_RD, 7, cycles a further rd is forbidden on a channel after its state-1 read.
- STARTUP_CYC, 4, cycles after reset release during which all input pulses are ignored.
- ERRW, 16, error counter width.

Ports:
- clk  in  1  system clock; all strobes are sampled on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- set_i  in  WIDTH  per-channel set pulse.
- clr_i  in  WIDTH  per-channel NDRO reset pulse (not the global reset).
- rd_i  in  1  shared readout pulse (the NDRO clk input).
- out_o  out  WIDTH  per-channel output pulse, one cycle wide.
- state_o  out  WIDTH  stored bit per channel, for debug.
- err_o  out  WIDTH  sticky per-channel violation flag.
- err_cnt_o  out  ERRW  saturating total violation count.

Behaviour:
- Reset values: all outputs 0. Also cleared: state bits, window counters, delay lines, startup counter reloaded to STARTUP_CYC.
- Startup guard: until the counter reaches 0, every input pulse is ignored, with no error.
- Reset mid-operation: pending out pulses are discarded and never emitted.
- Per channel, two states: S0 (empty) and S1 (stored). Each cycle, all events are evaluated against the state at the cycle start.
- set in S0 → S1. set in S1 → no change.
- clr in S0 → stays S0; opens set window = CT_CLR_SET_S0.
- clr in S1 → S0; opens set window = CT_CLR_SET_S1.
- rd in S0 → nothing.
- rd in S1:
  - stays S1;
  - out_o pulses exactly DLY_RD_OUT cycles later;
  - opens clr window = CT_RD_CLR and rd window = CT_RD_RD.
- Windows: a counter is loaded with CT and decrements each cycle. The window is active while the counter is nonzero and includes the trigger cycle itself. A CT of 0 disables the check.
- Violation = a pulse arriving while its window is active. The pulse is ignored (no state change, no new window). The channel's err_o is set sticky, and err_cnt_o increments by 1 per violating pulse, saturating at all-ones.
  - Multiple channels violating in the same cycle add their total count.
- Violation does not cancel an already-scheduled out pulse.
- Simultaneous events on one channel in the same cycle:
  - set+clr: clr acts; set is a violation if the opened CT is greater than 0, else the set is then applied → S1.
  - rd+clr in S1: read acts on S1 (out scheduled); the clr is a violation because the clr window opens in the same cycle.
  - rd+set in S0: rd sees S0 (no out); set → S1.
- Delay line: a per-channel shift register of depth DLY_RD_OUT. Reads spaced at least CT_RD_RD apart never overlap. Overlapping reads cannot occur because they are violations.
- err_o and err_cnt_o clear only on reset.

Decomposition:
- Package ndro_emu_pkg holds:
  - default timing constants (DLY/CT values above);
  - the state enum {NDRO_S0, NDRO_S1};
  - the saturating-increment function for the counter.
- Sub-module ndro_emu_cell implements one channel: state, three window counters, delay line, violation output. It is generated WIDTH times.
- The bank owns the startup guard, the rd fan-out and the error popcount/counter.

Test Plan:
1. reset, release; set_i[0] at cycle 2 (inside guard) → ignored, state_o=0; set_i[0] at cycle 6 → state_o[0]=1 next cycle, no error.
2. Ch0 in S1, rd_i at cycle T → out_o[0]=1 at exactly T+7 for one cycle; rd again at T+7 → second out at T+14, err_o=0.
3. Ch0 in S1, rd at T, rd at T+3 → err_o[0]=1, err_cnt_o=1, only one out pulse at T+7.
4. Ch1 in S1, rd at T, clr_i[1] at T+1 → violation, state stays S1, err_cnt_o increments; clr at T+2 → accepted, S0.
5. clr_i[2] with ch2 in S0, set_i[2] next cycle → violation (CT_CLR_SET_S0=2), state stays S0; set at +2 → S1.
6. Error counter: with ERRW=2, inject 5 violations → err_cnt_o saturates at 3. Then assert reset mid-delay with a pending out → no out emitted, all outputs 0.

Source files
------------

// File: rtl/ndro_emu_pkg.sv
// ---------------------------------------------------------------------------
// ndro_emu_pkg
// Shared definitions for the NDRO emulation bank:
//   - default timing constants, all expressed in system-clock cycles
//   - the per-channel storage state enum
//   - a saturating add used by the violation counter
// No ports (package).
// ---------------------------------------------------------------------------
package ndro_emu_pkg;

  // Default timing, in clock cycles.
  localparam int DLY_RD_OUT_DEF    = 7;
  localparam int CT_CLR_SET_S0_DEF = 2;
  localparam int CT_CLR_SET_S1_DEF = 1;
  localparam int CT_RD_CLR_DEF     = 2;
  localparam int CT_RD_RD_DEF      = 7;
  localparam int STARTUP_CYC_DEF   = 4;

  // Window counters are sized for critical-timing values up to 31 cycles.
  localparam int CT_W = 5;

  // Stored bit of one NDRO cell.
  typedef enum logic {
    NDRO_S0 = 1'b0,  // empty
    NDRO_S1 = 1'b1   // stored
  } ndro_state_e;

  // Adds inc to cur and clamps the result at max_val.
  function automatic logic [31:0] sat_inc(input logic [31:0] cur,
                                          input logic [31:0] inc,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, cur} + {1'b0, inc};
    if (sum > {1'b0, max_val}) begin
      return max_val;
    end else begin
      return sum[31:0];
    end
  endfunction

endpackage

// File: rtl/ndro_emu_bank_if.sv
// ---------------------------------------------------------------------------
// ndro_emu_bank_if
// Pulse and status bundle of the NDRO emulation bank.
//   set_i     WIDTH  per-channel set pulse
//   clr_i     WIDTH  per-channel NDRO clear pulse
//   rd_i      1      shared readout pulse
//   out_o     WIDTH  per-channel output pulse
//   state_o   WIDTH  stored bit per channel
//   err_o     WIDTH  sticky per-channel violation flag
//   err_cnt_o ERRW   saturating violation count
// master drives the pulses, slave (the bank) drives the status.
// ---------------------------------------------------------------------------
interface ndro_emu_bank_if #(
  parameter int WIDTH = 8,
  parameter int ERRW  = 16
) ();

  logic [WIDTH-1:0] set_i;
  logic [WIDTH-1:0] clr_i;
  logic             rd_i;
  logic [WIDTH-1:0] out_o;
  logic [WIDTH-1:0] state_o;
  logic [WIDTH-1:0] err_o;
  logic [ERRW-1:0]  err_cnt_o;

  modport master (
    output set_i, clr_i, rd_i,
    input  out_o, state_o, err_o, err_cnt_o
  );

  modport slave (
    input  set_i, clr_i, rd_i,
    output out_o, state_o, err_o, err_cnt_o
  );

endinterface

// File: rtl/ndro_emu_cell.sv
// ---------------------------------------------------------------------------
// ndro_emu_cell
// One NDRO channel: stored state, the three critical-timing windows
// (clr->set, rd->clr, rd->rd), the readout delay line and the per-cycle
// violation count.
//   clk       system clock
//   rst       asynchronous active-high reset
//   i_set     set pulse (already startup-gated)
//   i_clr     clear pulse (already startup-gated)
//   i_rd      readout pulse (already startup-gated)
//   o_out     output pulse, DLY_RD_OUT cycles after an accepted state-1 read
//   o_state   stored bit
//   o_viol_n  number of pulses rejected this cycle (0..3)
// ---------------------------------------------------------------------------
module ndro_emu_cell
  import ndro_emu_pkg::*;
#(
  parameter int DLY_RD_OUT    = DLY_RD_OUT_DEF,
  parameter int CT_CLR_SET_S0 = CT_CLR_SET_S0_DEF,
  parameter int CT_CLR_SET_S1 = CT_CLR_SET_S1_DEF,
  parameter int CT_RD_CLR     = CT_RD_CLR_DEF,
  parameter int CT_RD_RD      = CT_RD_RD_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_set,
  input  logic       i_clr,
  input  logic       i_rd,
  output logic       o_out,
  output logic       o_state,
  output logic [1:0] o_viol_n
);

  localparam logic [CT_W-1:0] CNT_ONE = CT_W'(1);

  // The trigger cycle is already part of the window, so the counter is
  // reloaded with CT-1; the trigger cycle itself is covered by the EN_* terms.
  localparam logic [CT_W-1:0] LD_SET_S0 = (CT_CLR_SET_S0 > 0) ? CT_W'(CT_CLR_SET_S0 - 1) : '0;
  localparam logic [CT_W-1:0] LD_SET_S1 = (CT_CLR_SET_S1 > 0) ? CT_W'(CT_CLR_SET_S1 - 1) : '0;
  localparam logic [CT_W-1:0] LD_RD_CLR = (CT_RD_CLR > 0) ? CT_W'(CT_RD_CLR - 1) : '0;
  localparam logic [CT_W-1:0] LD_RD_RD  = (CT_RD_RD > 0) ? CT_W'(CT_RD_RD - 1) : '0;
  localparam logic EN_SET_S0 = (CT_CLR_SET_S0 > 0);
  localparam logic EN_SET_S1 = (CT_CLR_SET_S1 > 0);
  localparam logic EN_RD_CLR = (CT_RD_CLR > 0);

  ndro_state_e           r_state;
  ndro_state_e           w_state_nx;
  logic [CT_W-1:0]       r_set_cnt;
  logic [CT_W-1:0]       r_clr_cnt;
  logic [CT_W-1:0]       r_rd_cnt;
  logic [DLY_RD_OUT-1:0] r_dly;

  logic            w_rd_win;
  logic            w_rd_viol;
  logic            w_rd_acc;
  logic            w_clr_win;
  logic            w_clr_viol;
  logic            w_clr_acc;
  logic            w_set_win;
  logic            w_set_viol;
  logic            w_set_acc;
  logic [CT_W-1:0] w_set_ld;
  logic            w_set_en;

  // Event evaluation against the state at cycle start; rd, then clr, then set,
  // because a same-cycle rd opens the clr window and a same-cycle clr opens
  // the set window.
  always_comb begin
    w_rd_win   = (r_rd_cnt != '0);
    w_rd_viol  = i_rd & w_rd_win;
    w_rd_acc   = i_rd & ~w_rd_win & (r_state == NDRO_S1);

    w_clr_win  = (r_clr_cnt != '0) | (w_rd_acc & EN_RD_CLR);
    w_clr_viol = i_clr & w_clr_win;
    w_clr_acc  = i_clr & ~w_clr_win;

    if (r_state == NDRO_S1) begin
      w_set_ld = LD_SET_S1;
      w_set_en = EN_SET_S1;
    end else begin
      w_set_ld = LD_SET_S0;
      w_set_en = EN_SET_S0;
    end

    w_set_win  = (r_set_cnt != '0) | (w_clr_acc & w_set_en);
    w_set_viol = i_set & w_set_win;
    w_set_acc  = i_set & ~w_set_win;
  end

  // Next-state logic; a set accepted alongside a clr wins (only possible
  // when the clr->set window is disabled).
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      NDRO_S0: begin
        if (w_set_acc) begin
          w_state_nx = NDRO_S1;
        end else begin
          w_state_nx = NDRO_S0;
        end
      end
      NDRO_S1: begin
        if (w_clr_acc && !w_set_acc) begin
          w_state_nx = NDRO_S0;
        end else begin
          w_state_nx = NDRO_S1;
        end
      end
      default: w_state_nx = NDRO_S0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= NDRO_S0;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Window counters: reload on an accepted trigger, otherwise count down to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_set_cnt <= '0;
      r_clr_cnt <= '0;
      r_rd_cnt  <= '0;
    end else begin
      if (w_clr_acc) begin
        r_set_cnt <= w_set_ld;
      end else if (r_set_cnt != '0) begin
        r_set_cnt <= r_set_cnt - CNT_ONE;
      end else begin
        r_set_cnt <= r_set_cnt;
      end

      if (w_rd_acc) begin
        r_clr_cnt <= LD_RD_CLR;
        r_rd_cnt  <= LD_RD_RD;
      end else begin
        r_clr_cnt <= (r_clr_cnt != '0) ? r_clr_cnt - CNT_ONE : r_clr_cnt;
        r_rd_cnt  <= (r_rd_cnt != '0) ? r_rd_cnt - CNT_ONE : r_rd_cnt;
      end
    end
  end

  // Readout delay line; stage k holds a read accepted k+1 cycles ago.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dly <= '0;
    end else begin
      r_dly[0] <= w_rd_acc;
      for (int k = 1; k < DLY_RD_OUT; k++) begin
        r_dly[k] <= r_dly[k-1];
      end
    end
  end

  assign o_out    = r_dly[DLY_RD_OUT-1];
  assign o_state  = (r_state == NDRO_S1);
  assign o_viol_n = {1'b0, w_rd_viol} + {1'b0, w_clr_viol} + {1'b0, w_set_viol};

endmodule

// File: rtl/ndro_emu_bank.sv
// ---------------------------------------------------------------------------
// ndro_emu_bank
// Bank of WIDTH emulated NDRO cells sharing one readout line. Owns the
// startup guard, the rd fan-out and the violation flags/counter.
//   clk    system clock; all pulses sampled on its rising edge
//   reset  asynchronous active-high reset
//   bus    ndro_emu_bank_if.slave: set_i/clr_i/rd_i in, out_o/state_o/
//          err_o/err_cnt_o out
// ---------------------------------------------------------------------------
module ndro_emu_bank
  import ndro_emu_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int DLY_RD_OUT    = DLY_RD_OUT_DEF,
  parameter int CT_CLR_SET_S0 = CT_CLR_SET_S0_DEF,
  parameter int CT_CLR_SET_S1 = CT_CLR_SET_S1_DEF,
  parameter int CT_RD_CLR     = CT_RD_CLR_DEF,
  parameter int CT_RD_RD      = CT_RD_RD_DEF,
  parameter int STARTUP_CYC   = STARTUP_CYC_DEF,
  parameter int ERRW          = 16
) (
  input  logic           clk,
  input  logic           reset,
  ndro_emu_bank_if.slave bus
);

  localparam int ST_W = (STARTUP_CYC > 1) ? $clog2(STARTUP_CYC + 1) : 1;
  localparam logic [ST_W-1:0] ST_ONE  = ST_W'(1);
  localparam logic [31:0]     ERR_MAX = 32'((64'd1 << ERRW) - 64'd1);

  logic [ST_W-1:0]  r_start_cnt;
  logic [WIDTH-1:0] r_err;
  logic [ERRW-1:0]  r_err_cnt;

  logic             w_run;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clr;
  logic             w_rd;
  logic [WIDTH-1:0] w_out;
  logic [WIDTH-1:0] w_state;
  logic [1:0]       w_viol_n [WIDTH];
  logic [WIDTH-1:0] w_viol_any;
  logic [31:0]      w_viol_sum;

  // Pulses are dropped silently while the startup counter is still running.
  assign w_run = (r_start_cnt == '0);
  assign w_set = bus.set_i & {WIDTH{w_run}};
  assign w_clr = bus.clr_i & {WIDTH{w_run}};
  assign w_rd  = bus.rd_i & w_run;

  // Startup guard counter, reloaded by reset and counting down to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_start_cnt <= ST_W'(STARTUP_CYC);
    end else if (r_start_cnt != '0) begin
      r_start_cnt <= r_start_cnt - ST_ONE;
    end else begin
      r_start_cnt <= r_start_cnt;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    ndro_emu_cell #(
      .DLY_RD_OUT    (DLY_RD_OUT),
      .CT_CLR_SET_S0 (CT_CLR_SET_S0),
      .CT_CLR_SET_S1 (CT_CLR_SET_S1),
      .CT_RD_CLR     (CT_RD_CLR),
      .CT_RD_RD      (CT_RD_RD)
    ) u_cell (
      .clk      (clk),
      .rst      (reset),
      .i_set    (w_set[g]),
      .i_clr    (w_clr[g]),
      .i_rd     (w_rd),
      .o_out    (w_out[g]),
      .o_state  (w_state[g]),
      .o_viol_n (w_viol_n[g])
    );
  end

  // Total rejected pulses this cycle across all channels.
  always_comb begin
    w_viol_sum = '0;
    w_viol_any = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_viol_sum    = w_viol_sum + 32'(w_viol_n[i]);
      w_viol_any[i] = (w_viol_n[i] != 2'd0);
    end
  end

  // Sticky flags and saturating counter; cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err     <= '0;
      r_err_cnt <= '0;
    end else begin
      r_err     <= r_err | w_viol_any;
      r_err_cnt <= ERRW'(sat_inc(32'(r_err_cnt), w_viol_sum, ERR_MAX));
    end
  end

  assign bus.out_o     = w_out;
  assign bus.state_o   = w_state;
  assign bus.err_o     = r_err;
  assign bus.err_cnt_o = r_err_cnt;

endmodule

// File: tb/tb_ndro_emu_bank.sv
// ---------------------------------------------------------------------------
// tb_ndro_emu_bank
// Directed bench for ndro_emu_bank (WIDTH=8, default timing, ERRW=2 so the
// counter saturates at 3). Inputs change 1 time unit after a rising edge;
// outputs are read at the same point, reflecting that edge.
// ---------------------------------------------------------------------------
module tb_ndro_emu_bank;

  localparam int WIDTH = 8;
  localparam int ERRW  = 2;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  ndro_emu_bank_if #(.WIDTH(WIDTH), .ERRW(ERRW)) bus ();

  ndro_emu_bank #(.WIDTH(WIDTH), .ERRW(ERRW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.set_i = 8'h00;
    bus.clr_i = 8'h00;
    bus.rd_i  = 1'b0;
  endtask

  // Reset, then let the 4-cycle startup guard expire: the next edge accepts.
  task automatic reset_and_settle();
    clear_inputs();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (2) step();
    checks++; if (bus.out_o !== 8'h00) begin errors++; $display("FAIL reset_out: got %h want %h", bus.out_o, 8'h00); end
    checks++; if (bus.state_o !== 8'h00) begin errors++; $display("FAIL reset_state: got %h want %h", bus.state_o, 8'h00); end
    checks++; if (bus.err_o !== 8'h00) begin errors++; $display("FAIL reset_err: got %h want %h", bus.err_o, 8'h00); end
    checks++; if (bus.err_cnt_o !== 2'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", bus.err_cnt_o); end
    reset = 1'b0;
    step();                      // edge 1 after release
    bus.set_i = 8'h01;
    step();                      // edge 2: inside the guard
    bus.set_i = 8'h00;
    checks++; if (bus.state_o !== 8'h00) begin errors++; $display("FAIL guard_state: got %h want %h", bus.state_o, 8'h00); end
    checks++; if (bus.err_o !== 8'h00) begin errors++; $display("FAIL guard_err: got %h want %h", bus.err_o, 8'h00); end
    repeat (3) step();           // edges 3..5
    bus.set_i = 8'h01;
    step();                      // edge 6: guard expired
    bus.set_i = 8'h00;
    checks++; if (bus.state_o !== 8'h01) begin errors++; $display("FAIL set_after_guard: got %h want %h", bus.state_o, 8'h01); end
    checks++; if (bus.err_o !== 8'h00) begin errors++; $display("FAIL set_after_guard_err: got %h want %h", bus.err_o, 8'h00); end
  endtask

  // Reads 7 apart: both accepted, outputs at T+7 and T+14.
  task automatic test_read_spacing();
    logic [7:0] exp_out;
    reset_and_settle();
    bus.set_i = 8'h01;
    step();
    bus.set_i = 8'h00;
    bus.rd_i = 1'b1;
    step();                      // rd sampled in cycle T; now in T+1
    for (int k = 1; k <= 16; k++) begin
      exp_out = (k == 7 || k == 14) ? 8'h01 : 8'h00;
      checks++; if (bus.out_o !== exp_out) begin errors++; $display("FAIL rd_spacing_out T+%0d: got %h want %h", k, bus.out_o, exp_out); end
      bus.rd_i = (k == 7);
      step();
    end
    checks++; if (bus.err_o !== 8'h00) begin errors++; $display("FAIL rd_spacing_err: got %h want %h", bus.err_o, 8'h00); end
    checks++; if (bus.err_cnt_o !== 2'd0) begin errors++; $display("FAIL rd_spacing_cnt: got %0d want 0", bus.err_cnt_o); end
  endtask

  // Second read 3 cycles after the first: violation, single output.
  task automatic test_read_violation();
    logic [7:0] exp_out;
    reset_and_settle();
    bus.set_i = 8'h01;
    step();
    bus.set_i = 8'h00;
    bus.rd_i = 1'b1;
    step();
    for (int k = 1; k <= 11; k++) begin
      exp_out = (k == 7) ? 8'h01 : 8'h00;
      checks++; if (bus.out_o !== exp_out) begin errors++; $display("FAIL rd_viol_out T+%0d: got %h want %h", k, bus.out_o, exp_out); end
      bus.rd_i = (k == 3);
      step();
    end
    checks++; if (bus.err_o !== 8'h01) begin errors++; $display("FAIL rd_viol_err: got %h want %h", bus.err_o, 8'h01); end
    checks++; if (bus.err_cnt_o !== 2'd1) begin errors++; $display("FAIL rd_viol_cnt: got %0d want 1", bus.err_cnt_o); end
  endtask

  // clr one cycle after a read is rejected; two cycles after is accepted.
  task automatic test_rd_clr_window();
    reset_and_settle();
    bus.set_i = 8'h02;
    step();
    bus.set_i = 8'h00;
    bus.rd_i = 1'b1;
    step();                      // now T+1
    bus.rd_i = 1'b0;
    bus.clr_i = 8'h02;
    step();                      // clr at T+1 sampled; now T+2
    checks++; if (bus.state_o !== 8'h02) begin errors++; $display("FAIL rd_clr_viol_state: got %h want %h", bus.state_o, 8'h02); end
    checks++; if (bus.err_o !== 8'h02) begin errors++; $display("FAIL rd_clr_viol_err: got %h want %h", bus.err_o, 8'h02); end
    checks++; if (bus.err_cnt_o !== 2'd1) begin errors++; $display("FAIL rd_clr_viol_cnt: got %0d want 1", bus.err_cnt_o); end
    step();                      // clr at T+2 sampled; now T+3
    bus.clr_i = 8'h00;
    checks++; if (bus.state_o !== 8'h00) begin errors++; $display("FAIL rd_clr_ok_state: got %h want %h", bus.state_o, 8'h00); end
    checks++; if (bus.err_cnt_o !== 2'd1) begin errors++; $display("FAIL rd_clr_ok_cnt: got %0d want 1", bus.err_cnt_o); end
    repeat (3) step();           // now T+6
    checks++; if (bus.out_o !== 8'h00) begin errors++; $display("FAIL rd_clr_out_early: got %h want %h", bus.out_o, 8'h00); end
    step();                      // T+7: scheduled output still fires
    checks++; if (bus.out_o !== 8'h02) begin errors++; $display("FAIL rd_clr_out: got %h want %h", bus.out_o, 8'h02); end
    step();
    checks++; if (bus.out_o !== 8'h00) begin errors++; $display("FAIL rd_clr_out_width: got %h want %h", bus.out_o, 8'h00); end
  endtask

  // clr in S0 blocks set for 2 cycles.
  task automatic test_clr_set_window();
    reset_and_settle();
    bus.clr_i = 8'h04;
    step();
    bus.clr_i = 8'h00;
    bus.set_i = 8'h04;
    step();                      // set at clr+1: rejected
    checks++; if (bus.state_o !== 8'h00) begin errors++; $display("FAIL clr_set_viol_state: got %h want %h", bus.state_o, 8'h00); end
    checks++; if (bus.err_o !== 8'h04) begin errors++; $display("FAIL clr_set_viol_err: got %h want %h", bus.err_o, 8'h04); end
    checks++; if (bus.err_cnt_o !== 2'd1) begin errors++; $display("FAIL clr_set_viol_cnt: got %0d want 1", bus.err_cnt_o); end
    step();                      // set at clr+2: accepted
    bus.set_i = 8'h00;
    checks++; if (bus.state_o !== 8'h04) begin errors++; $display("FAIL clr_set_ok_state: got %h want %h", bus.state_o, 8'h04); end
    checks++; if (bus.err_cnt_o !== 2'd1) begin errors++; $display("FAIL clr_set_ok_cnt: got %0d want 1", bus.err_cnt_o); end
  endtask

  // Same-cycle combinations: rd+set in S0, rd+clr in S1, set+clr in S1.
  task automatic test_simultaneous();
    logic [7:0] exp_out;
    reset_and_settle();
    bus.set_i = 8'h10;
    step();
    bus.rd_i  = 1'b1;
    bus.set_i = 8'h08;
    bus.clr_i = 8'h10;
    step();
    clear_inputs();
    checks++; if (bus.state_o !== 8'h18) begin errors++; $display("FAIL simul_state: got %h want %h", bus.state_o, 8'h18); end
    checks++; if (bus.err_o !== 8'h10) begin errors++; $display("FAIL simul_err: got %h want %h", bus.err_o, 8'h10); end
    checks++; if (bus.err_cnt_o !== 2'd1) begin errors++; $display("FAIL simul_cnt: got %0d want 1", bus.err_cnt_o); end
    for (int k = 1; k <= 8; k++) begin
      exp_out = (k == 7) ? 8'h10 : 8'h00;
      checks++; if (bus.out_o !== exp_out) begin errors++; $display("FAIL simul_out T+%0d: got %h want %h", k, bus.out_o, exp_out); end
      step();
    end
    bus.set_i = 8'h08;
    bus.clr_i = 8'h08;
    step();
    clear_inputs();
    checks++; if (bus.state_o !== 8'h10) begin errors++; $display("FAIL set_clr_s1_state: got %h want %h", bus.state_o, 8'h10); end
    checks++; if (bus.err_o !== 8'h18) begin errors++; $display("FAIL set_clr_s1_err: got %h want %h", bus.err_o, 8'h18); end
    checks++; if (bus.err_cnt_o !== 2'd2) begin errors++; $display("FAIL set_clr_s1_cnt: got %0d want 2", bus.err_cnt_o); end
  endtask

  // Five violations saturate the 2-bit counter; reset discards a pending out.
  task automatic test_saturation_and_reset();
    reset_and_settle();
    bus.clr_i = 8'h60;
    bus.set_i = 8'h60;
    step();                      // 2 violations
    checks++; if (bus.err_cnt_o !== 2'd2) begin errors++; $display("FAIL sat_cnt_2: got %0d want 2", bus.err_cnt_o); end
    bus.clr_i = 8'h80;
    bus.set_i = 8'hE0;
    step();                      // 3 more violations
    clear_inputs();
    checks++; if (bus.err_cnt_o !== 2'd3) begin errors++; $display("FAIL sat_cnt_3: got %0d want 3", bus.err_cnt_o); end
    checks++; if (bus.err_o !== 8'hE0) begin errors++; $display("FAIL sat_err: got %h want %h", bus.err_o, 8'hE0); end
    checks++; if (bus.state_o !== 8'h00) begin errors++; $display("FAIL sat_state: got %h want %h", bus.state_o, 8'h00); end
    bus.set_i = 8'h01;
    step();
    bus.set_i = 8'h00;
    bus.rd_i = 1'b1;
    step();                      // now T+1
    bus.rd_i = 1'b0;
    repeat (3) step();           // now T+4, out pending
    reset = 1'b1;
    #1;
    checks++; if (bus.out_o !== 8'h00) begin errors++; $display("FAIL midrst_out: got %h want %h", bus.out_o, 8'h00); end
    checks++; if (bus.state_o !== 8'h00) begin errors++; $display("FAIL midrst_state: got %h want %h", bus.state_o, 8'h00); end
    checks++; if (bus.err_o !== 8'h00) begin errors++; $display("FAIL midrst_err: got %h want %h", bus.err_o, 8'h00); end
    checks++; if (bus.err_cnt_o !== 2'd0) begin errors++; $display("FAIL midrst_cnt: got %0d want 0", bus.err_cnt_o); end
    repeat (2) step();
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      checks++; if (bus.out_o !== 8'h00) begin errors++; $display("FAIL midrst_no_out %0d: got %h want %h", k, bus.out_o, 8'h00); end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    clear_inputs();
    test_reset();
    test_read_spacing();
    test_read_violation();
    test_rd_clr_window();
    test_clr_set_window();
    test_simultaneous();
    test_saturation_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
